// File: rtl/tvm_loop_nest.sv
// tvm_loop_nest: run-time programmable NUM_LEVELS-deep loop nest iterator with handshake, repeat and done/busy.
// Optional per-level step port enabled by TVM_LOOP_STEP_EN; otherwise every level steps by 1.
module tvm_loop_nest #(
    parameter int NUM_LEVELS = 2,
    parameter int WIDTH      = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          cfg_repeat,
    input  logic [NUM_LEVELS*WIDTH-1:0]   cfg_begin,
    input  logic [NUM_LEVELS*WIDTH-1:0]   cfg_extent,
`ifdef TVM_LOOP_STEP_EN
    input  logic [NUM_LEVELS*WIDTH-1:0]   cfg_step,
`endif
    input  logic                          ready,
    output logic [NUM_LEVELS*WIDTH-1:0]   iter,
    output logic                          valid,
    output logic [NUM_LEVELS-1:0]         level_wrap,
    output logic                          last,
    output logic                          busy,
    output logic                          done
);
    typedef enum logic {IDLE, RUN} state_t;
    typedef logic [NUM_LEVELS-1:0][WIDTH-1:0] vec_t;
    state_t state, state_d;
    vec_t beg, ext, stp, idx, val;
    vec_t beg_d, ext_d, idx_d, val_d, cfg_beg, cfg_ext;
    logic rep, rep_d, done_d, fire, zero;
    logic [NUM_LEVELS-1:0] wrap_d;
    logic [NUM_LEVELS:0] carry, wcarry;

    assign cfg_beg = cfg_begin;
    assign cfg_ext = cfg_extent;
    assign fire = (state == RUN) && ready;
    assign iter = val;
    assign valid = state == RUN;
    assign busy = state == RUN;
    assign last = level_wrap[NUM_LEVELS-1];

`ifdef TVM_LOOP_STEP_EN
    vec_t cfg_stp;
    assign cfg_stp = cfg_step;
    always_ff @(posedge clk or negedge rst)
        if (!rst) stp <= '0;
        else if (state == IDLE && start) stp <= cfg_stp;
`else
    assign stp = {NUM_LEVELS{WIDTH'(1)}};
`endif

    // carry[i] means every level below i is on its final index, so level i advances
    always_comb begin
        state_d = state;
        beg_d = beg;
        ext_d = ext;
        rep_d = rep;
        idx_d = idx;
        val_d = val;
        done_d = 1'b0;
        zero = 1'b0;
        carry[0] = 1'b1;
        for (int i = 0; i < NUM_LEVELS; i++) begin
            carry[i+1] = carry[i] && (idx[i] == ext[i] - WIDTH'(1));
            zero = zero || (cfg_ext[i] == '0);
        end
        if (fire) begin
            for (int i = 0; i < NUM_LEVELS; i++)
                if (carry[i]) begin
                    idx_d[i] = carry[i+1] ? '0 : idx[i] + WIDTH'(1);
                    val_d[i] = carry[i+1] ? beg[i] : val[i] + stp[i];
                end
            if (carry[NUM_LEVELS]) begin
                done_d = 1'b1;
                state_d = rep ? RUN : IDLE;
            end
        end else if (state == IDLE && start) begin
            beg_d = cfg_beg;
            ext_d = cfg_ext;
            rep_d = cfg_repeat;
            idx_d = '0;
            val_d = cfg_beg;
            done_d = zero;
            state_d = zero ? IDLE : RUN;
        end
        wcarry[0] = 1'b1;
        for (int i = 0; i < NUM_LEVELS; i++)
            wcarry[i+1] = wcarry[i] && (idx_d[i] == ext_d[i] - WIDTH'(1));
        wrap_d = wcarry[NUM_LEVELS:1];
    end

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state <= IDLE;
            beg <= '0;
            ext <= '0;
            rep <= 1'b0;
            idx <= '0;
            val <= '0;
            level_wrap <= '0;
            done <= 1'b0;
        end else begin
            state <= state_d;
            beg <= beg_d;
            ext <= ext_d;
            rep <= rep_d;
            idx <= idx_d;
            val <= val_d;
            level_wrap <= wrap_d;
            done <= done_d;
        end
endmodule

// File: doc/tvm_loop_nest.md
# tvm_loop_nest

Parametrised nested-loop iteration generator for TVM verilog test benches and generated kernels. It emits the full index tuple of an `NUM_LEVELS`-deep loop nest, one tuple per accepted handshake, with per-level begin, extent and wrap flags. Bounds are programmed at run time and sampled on `start`. It supersedes hand-chained single-level nonstop loops by adding backpressure, a one-shot or repeat mode, and done/busy status.

## Interface
- `NUM_LEVELS`, 2: loop depth; level 0 is innermost.
- `WIDTH`, 4: bit width of every counter, begin, extent and step field.
- `clk  input  1`: clock, rising edge.
- `rst  input  1`: asynchronous active-low reset; one clock, and reset is asynchronous and active-low.
- `start  input  1`: pulse; samples configuration and launches the nest when idle.
- `cfg_repeat  input  1`: sampled on `start`; 1 restarts the nest automatically after the last tuple.
- `cfg_begin  input  NUM_LEVELS*WIDTH`: per-level first value; level i at bits [i*WIDTH +: WIDTH].
- `cfg_extent  input  NUM_LEVELS*WIDTH`: per-level trip count, unsigned.
- `cfg_step  input  NUM_LEVELS*WIDTH`: per-level increment. Present only with `TVM_LOOP_STEP_EN`.
- `iter  output  NUM_LEVELS*WIDTH`: current index tuple.
- `valid  output  1`: `iter` holds a tuple.
- `ready  input  1`: consumer accepts the tuple when `valid && ready`.
- `level_wrap  output  NUM_LEVELS`: bit i is high when levels 0..i are all on their final index in the current tuple.
- `last  output  1`: equals `level_wrap[NUM_LEVELS-1]`.
- `busy  output  1`: state is not IDLE.
- `done  output  1`: one-cycle pulse at the end of each pass.

## Operation
- The block has two states, IDLE and RUN. Reset forces IDLE, `valid`=0, `done`=0, `busy`=0, `iter`=0 and `level_wrap`=0.
- **IDLE + `start`**: latch `cfg_*` into shadow registers.
  - If any extent is 0, stay in IDLE, keep `valid` at 0, and pulse `done` on the next cycle.
  - Otherwise go to RUN, load `iter` = begin and the index counters = 0, and set `valid`=1.
- **RUN + `start`**: ignored. The shadow configuration does not change.
- **RUN + accepted tuple**: advance like an odometer.
  - Level 0 index increments.
  - When level i is on its final index (index == extent-1), it reloads begin/index 0 and level i+1 advances.
- **Accepted last tuple**: pulse `done` on the next cycle.
  - With `cfg_repeat`=1: reload all levels and stay in RUN; `valid` stays 1.
  - With `cfg_repeat`=0: go to IDLE and drop `valid`.
- **Counter arithmetic**:
  - The index counters count trip number and are independent of the `iter` value. Termination is by index, never by comparing `iter`.
  - `iter` per level = begin + index*step, computed incrementally as `iter` + step, modulo 2^WIDTH. Overflow wraps silently.
  - Maximum extent is 2^WIDTH-1.
- **Stall**: while `valid && !ready`, `iter`, `level_wrap` and `last` hold stable.
- **Pass size**: tuples per pass = product of the extents.

## Timing
- `start` at cycle t: first tuple is valid at t+1.
- Zero-extent `start` at cycle t: `done` at t+1.
- Throughput is one tuple per cycle while `ready` is held high. There is no bubble between passes in repeat mode.
- `level_wrap` and `last` are registered and coincident with their tuple.
- `done` rises the cycle after the last tuple handshake and lasts exactly one cycle.
- `busy` rises the cycle after `start` and falls in the same cycle `done` rises.
- When IDLE→RUN via `start` and a final handshake coincide in the same cycle, the handshake wins and `start` is ignored. `start` needs `busy`=0.
- Asserting `rst` mid-pass clears all state immediately, without waiting for a clock edge. After release the block needs a fresh `start`.

## Configuration
- `TVM_LOOP_STEP_EN` defined:
  - `cfg_step` port exists and is latched on `start`.
  - Each level advances by its step. A step of 0 repeats begin for `extent` trips.
- Undefined:
  - No `cfg_step` port; every step is the constant 1.
  - The multiply-free adder path is unchanged.

## Test plan
- **Basic nest**: `NUM_LEVELS`=2, `WIDTH`=4, begin (0,0), extent (4,3), `ready`=1, `start` at cycle 5 → 12 tuples on cycles 6–17, ordered (0,0),(1,0),(2,0),(3,0),(0,1)…(3,2).
  - `level_wrap[0]` is high on every 4th tuple.
  - `last` is high only on (3,2).
  - `done` pulses at cycle 18 and `busy` is 0 from cycle 18.
- **Backpressure**: same configuration with `ready` toggled pseudo-randomly → the same 12-tuple sequence. `iter` never changes while `valid && !ready`, and no tuple is duplicated or skipped.
- **Zero extent and start-while-busy**:
  - extent (0,3) → `valid` never rises and `done` pulses one cycle after `start`.
  - A second `start` mid-pass → no effect on the sequence.
- **Repeat mode**: `cfg_repeat`=1, extent (2,2), begin (5,14) → tuples (5,14),(6,14),(5,15),(6,15) repeat back-to-back. `done` pulses after every 4th handshake and `valid` never drops.
- **Async reset**: pull `rst` low between clock edges during tuple 7 → `valid`, `busy` and `iter` read 0 before the next edge. After release, `start` reproduces the full sequence from (0,0).
- **Step (`TVM_LOOP_STEP_EN`)**: begin (14,0), step (3,1), extent (3,2) → level 0 values 14,1,4 (mod 16), repeated for level 1 = 0 and 1, 6 tuples in total.
